// File: rtl/prod_uart_tx.sv
// prod_uart_tx: sends a 16-bit product as two back-to-back 8N1 UART frames.
// A start/busy/done handshake faces the control logic. The product is copied
// into a shadow register when start is accepted, so prod may change during
// the transfer. There is no flow control on the serial line.
module prod_uart_tx #(
  parameter int CLKS_PER_BIT   = 87,
  parameter bit LOW_BYTE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] prod,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic            byte_idx;
  logic [15:0]     shadow;
  logic [7:0]      shifter;
  logic            baud_wrap;

  // Select the byte carried by the first (second=0) or second (second=1) frame.
  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic second);
    logic take_low;
    take_low = LOW_BYTE_FIRST ^ second;
    if (take_low) begin
      return word[7:0];
    end else begin
      return word[15:8];
    end
  endfunction

  assign baud_wrap = (baud_cnt == BAUD_MAX);

  // Transmit FSM: baud timing, bit/byte sequencing and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 1'b0;
      shadow   <= 16'h0000;
      shifter  <= 8'h00;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          byte_idx <= 1'b0;
          if (start) begin
            shadow  <= prod;
            shifter <= pick_byte(prod, 1'b0);
            state   <= S_START;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            state    <= S_DATA;
            tx       <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shifter <= {1'b0, shifter[7:1]};
              tx      <= shifter[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (byte_idx == 1'b0) begin
              // Chain straight into the second frame with no idle gap.
              byte_idx <= 1'b1;
              shifter  <= pick_byte(shadow, 1'b1);
              state    <= S_START;
              tx       <= 1'b0;
            end else begin
              byte_idx <= 1'b0;
              state    <= S_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              tx       <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_uart_tx.sv
// Bench for prod_uart_tx: three instances (4 clk/bit low-first, 4 clk/bit
// high-first, 2 clk/bit low-first), table vectors, hand-written corner
// sequences and random transfers checked against a frame-level line model.
module tb_prod_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [3];
  logic [15:0] prod  [3];
  logic        busy  [3];
  logic        done  [3];
  logic        tx    [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prod_uart_tx #(.CLKS_PER_BIT(4), .LOW_BYTE_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .prod(prod[0]),
    .busy(busy[0]), .done(done[0]), .tx(tx[0]));
  prod_uart_tx #(.CLKS_PER_BIT(4), .LOW_BYTE_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .prod(prod[1]),
    .busy(busy[1]), .done(done[1]), .tx(tx[1]));
  prod_uart_tx #(.CLKS_PER_BIT(2), .LOW_BYTE_FIRST(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .prod(prod[2]),
    .busy(busy[2]), .done(done[2]), .tx(tx[2]));

  typedef struct {
    int   busy_cycles;
    int   first_busy;
    int   done_in_busy;
    int   done_at_fall;
    int   tx_at_fall;
    int   timeout;
    int   wave_err;
    logic [7:0] b0;
    logic [7:0] b1;
  } res_t;

  typedef struct {
    int          k;
    logic [15:0] p;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  bit last_wave[$];

  function automatic int cpb_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic bit lbf_of(input int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  // Reference: byte carried by frame f of a transfer of p on instance k.
  function automatic logic [7:0] ref_byte(input int k, input logic [15:0] p, input int f);
    int lo;
    int hi;
    lo = int'(p) % 256;
    hi = int'(p) / 256;
    if (lbf_of(k) == (f == 0)) return 8'(lo);
    return 8'(hi);
  endfunction

  // Reference: line level j cycles after acceptance (start 0, 8 data LSB first, stop 1).
  function automatic int ref_bit(input int k, input logic [15:0] p, input int j);
    int cpb;
    int f;
    int pos;
    logic [7:0] b;
    cpb = cpb_of(k);
    f   = j / (10 * cpb);
    pos = (j % (10 * cpb)) / cpb;
    if (pos == 0) return 0;
    if (pos == 9) return 1;
    b = ref_byte(k, p, f);
    return int'(b[pos - 1]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic kick(input int k, input logic [15:0] p);
    @(negedge clk);
    prod[k]  = p;
    start[k] = 1'b1;
  endtask

  // Watch one transfer from the cycle after acceptance until busy drops.
  task automatic watch(input int k, input logic [15:0] exp_p, input int hold,
                       input int alt_at, input logic [15:0] alt_p,
                       input bit chain, input logic [15:0] chain_p, output res_t r);
    bit q[$];
    int n;
    int lim;
    int cpb;
    int idx;
    cpb = cpb_of(k);
    r = '{default: 0};
    r.timeout = 1;
    lim = 20 * cpb + 8;
    n = 0;
    while (n < lim) begin
      @(negedge clk);
      n++;
      if (n == 1) r.first_busy = int'(busy[k]);
      if (n >= hold) start[k] = 1'b0;
      if (n == alt_at) prod[k] = alt_p;
      if (busy[k]) begin
        q.push_back(tx[k]);
        r.busy_cycles++;
        r.done_in_busy += int'(done[k]);
      end else begin
        r.done_at_fall = int'(done[k]);
        r.tx_at_fall   = int'(tx[k]);
        r.timeout      = 0;
        if (chain) begin
          prod[k]  = chain_p;
          start[k] = 1'b1;
        end
        break;
      end
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        idx = f * 10 * cpb + (1 + i) * cpb + cpb / 2;
        if (idx < q.size() && q[idx]) begin
          if (f == 0) r.b0[i] = 1'b1;
          else        r.b1[i] = 1'b1;
        end
      end
    end
    for (int j = 0; j < q.size(); j++) begin
      if (int'(q[j]) != ref_bit(k, exp_p, j)) r.wave_err++;
    end
    last_wave = q;
  endtask

  task automatic check_res(input string name, input int k, input logic [7:0] e0,
                           input logic [7:0] e1, input res_t r);
    chk({name, "_byte0"}, int'(r.b0), int'(e0));
    chk({name, "_byte1"}, int'(r.b1), int'(e1));
    chk({name, "_busy_len"}, r.busy_cycles, 20 * cpb_of(k));
    chk({name, "_latency"}, r.first_busy, 1);
    chk({name, "_done_early"}, r.done_in_busy, 0);
    chk({name, "_done_pulse"}, r.done_at_fall, 1);
    chk({name, "_idle_tx"}, r.tx_at_fall, 1);
    chk({name, "_timeout"}, r.timeout, 0);
    chk({name, "_wave"}, r.wave_err, 0);
  endtask

  task automatic quiet(input int k, input int n, output int bz, output int dn);
    bz = 0;
    dn = 0;
    repeat (n) begin
      @(negedge clk);
      bz += int'(busy[k]);
      dn += int'(done[k]);
    end
  endtask

  initial begin
    vec_t tbl[6];
    res_t r;
    res_t r2;
    int   bz;
    int   dn;
    int   bad;
    int   a55a_bits[20] = '{0,0,1,0,1,1,0,1,0,1, 0,1,0,1,0,0,1,0,1,1};

    tbl[0] = '{0, 16'hA55A, 8'h5A, 8'hA5};
    tbl[1] = '{1, 16'h1234, 8'h12, 8'h34};
    tbl[2] = '{2, 16'hFFFF, 8'hFF, 8'hFF};
    tbl[3] = '{0, 16'h0000, 8'h00, 8'h00};
    tbl[4] = '{1, 16'h8001, 8'h80, 8'h01};
    tbl[5] = '{2, 16'h00FF, 8'hFF, 8'h00};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      prod[k]  = 16'h0000;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_tx", int'(tx[k]), 1);
      chk("reset_busy", int'(busy[k]), 0);
      chk("reset_done", int'(done[k]), 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table vectors.
    for (int v = 0; v < 6; v++) begin
      kick(tbl[v].k, tbl[v].p);
      watch(tbl[v].k, tbl[v].p, 1, 0, 16'h0000, 1'b0, 16'h0000, r);
      check_res($sformatf("vec%0d", v), tbl[v].k, tbl[v].e0, tbl[v].e1, r);
      if (v == 0) begin
        bad = 0;
        for (int b = 0; b < 20; b++) begin
          if (b * 4 + 2 >= last_wave.size() || int'(last_wave[b * 4 + 2]) != a55a_bits[b]) bad++;
        end
        chk("a55a_bit_seq", bad, 0);
      end
      repeat (3) @(negedge clk);
    end

    // Start held for 10 cycles, prod changed mid-transfer: one transfer of the latched value.
    kick(0, 16'h00FF);
    watch(0, 16'h00FF, 10, 20, 16'hFFFF, 1'b0, 16'h0000, r);
    check_res("busy_ignore", 0, 8'hFF, 8'h00, r);
    quiet(0, 30, bz, dn);
    chk("busy_ignore_no_retrigger", bz, 0);
    chk("busy_ignore_no_extra_done", dn, 0);

    // Back-to-back: start raised in the done cycle.
    kick(0, 16'h1234);
    watch(0, 16'h1234, 1, 0, 16'h0000, 1'b1, 16'h8001, r);
    check_res("b2b_first", 0, 8'h34, 8'h12, r);
    watch(0, 16'h8001, 1, 0, 16'h0000, 1'b0, 16'h0000, r2);
    check_res("b2b_second", 0, 8'h01, 8'h80, r2);
    repeat (3) @(negedge clk);

    // Random transfers against the line model.
    for (int it = 0; it < 12; it++) begin
      int k;
      int hold;
      int alt_at;
      logic [15:0] p;
      logic [15:0] alt;
      k      = int'($urandom_range(0, 2));
      p      = 16'($urandom);
      alt    = 16'($urandom);
      hold   = int'($urandom_range(1, 6));
      alt_at = int'($urandom_range(2, 30));
      kick(k, p);
      watch(k, p, hold, alt_at, alt, 1'b0, 16'h0000, r);
      check_res($sformatf("rand%0d", it), k, ref_byte(k, p, 0), ref_byte(k, p, 1), r);
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    // Reset in the middle of the first data byte.
    kick(0, 16'hA55A);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset_busy", int'(busy[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("midframe_reset_tx", int'(tx[0]), 1);
    chk("midframe_reset_busy", int'(busy[0]), 0);
    chk("midframe_reset_done", int'(done[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    chk("post_reset_idle", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prod_uart_tx.md
Name: prod_uart_tx

Overview:
Serializes the 16-bit multiplier product onto a single UART TX line as two back-to-back 8N1 frames.
Sits between the 8x8 multiplier (prod_high/prod_low) and the chip's serial output pin.
Forms the transmit end of the UART path whose operand side is fed by the UART receiver.
Pure transmitter: a start/busy/done handshake with the control logic and no flow control on the line.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit; legal range >= 2 (87 gives ~115200 baud at 10 MHz).
LOW_BYTE_FIRST, 1, 1 = send prod[7:0] then prod[15:8]; 0 = high byte first.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request to transmit prod; sampled on the rising edge.
prod  input  16  product to send; captured in the cycle start is accepted.
busy  output  1  high while a 2-byte transfer is in progress.
done  output  1  one-cycle pulse when the final stop bit has completed.
tx  output  1  UART serial line; idle high.

Behaviour:
- Reset (async assert, sync-safe deassert): tx=1, busy=0, done=0, FSM=IDLE, bit counter=0, baud counter=0, byte index=0. Reset mid-frame aborts immediately; tx returns high with no partial stop bit.
- All outputs are registered. tx is never driven combinationally.
- FSM states:
  - IDLE: tx=1, busy=0.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- Acceptance: start=1 while busy=0 latches prod into a 16-bit shadow register and enters START. The next edge shows busy=1 and tx=0, i.e. 1 cycle latency.
- Byte order: the first frame carries prod[7:0] if LOW_BYTE_FIRST=1, otherwise prod[15:8]. The second frame carries the other byte.
- Frame chaining: after the first STOP completes, go directly to START of the second frame with no idle gap. After the second STOP, return to IDLE.
- Transfer length: exactly 20*CLKS_PER_BIT cycles with busy=1. In the cycle busy falls, done=1 for exactly one cycle.
- start while busy=1 is ignored. prod changes during a transfer do not affect the frame being sent (shadow register).
- start in the same cycle done pulses is accepted, since busy=0 in that cycle. This gives back-to-back transfers with a single idle-high clock between frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The bit advances on wrap. Width is $clog2(CLKS_PER_BIT).
- start held high continuously: a new transfer begins each time busy returns low.

Test Plan:
- Reset: assert rst mid-DATA of the first byte -> same cycle tx=1, busy=0, done=0. After release, tx stays 1 until start.
- Basic frame, CLKS_PER_BIT=4, LOW_BYTE_FIRST=1, prod=16'hA55A, 1-cycle start pulse:
  - tx bit sequence, each bit 4 cycles: 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1.
  - busy high exactly 80 cycles; done pulses once at cycle 81.
- Byte order: LOW_BYTE_FIRST=0, prod=16'h1234 -> first frame decodes 8'h12, second 8'h34.
- Busy-ignore: start held for 10 cycles with prod=16'h00FF, then prod changed to 16'hFFFF mid-transfer -> exactly one transfer, decoded bytes FF then 00, one done pulse.
- Back-to-back: start asserted in the done cycle with prod=16'h8001 -> the second transfer starts next cycle and decodes 01 then 80. Only 1 idle clock appears between the two transfers.
- Boundary baud: CLKS_PER_BIT=2, prod=16'hFFFF -> the receiver model decodes FF,FF; busy=1 for exactly 40 cycles.
